// File: rtl/echo_delay_line_if.sv
// Sample-path bus between the sample source and the echo/delay stage.
//   in_data   : signed input sample (source -> stage)
//   wren      : one-cycle strobe qualifying in_data (source -> stage)
//   out_data  : signed processed sample (stage -> mixer)
//   out_valid : strobe qualifying out_data (stage -> mixer)
// The master modport belongs to the sample source; the slave modport belongs to the stage.
interface echo_delay_line_if #(
  parameter int unsigned WIDTH = 24
) ();

  logic [WIDTH-1:0] in_data;
  logic             wren;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  modport master (
    output in_data,
    output wren,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  wren,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/echo_delay_line.sv
// Mono echo/delay stage for the sound-mixer sample path.
// A circular buffer of DEPTH samples provides a runtime delay of delay_len+1 samples.
// The delayed sample is mixed with the dry input using a 2^-mix_shift wet weight.
// In feed-forward mode the buffer holds dry input, which gives a single echo.
// In feedback mode the buffer holds the mixed output, which gives decaying repeats.
// Ports:
//   clk       : sample-path clock
//   reset     : asynchronous active-low reset
//   smp       : sample bus (in_data/wren in, out_data/out_valid out), one-cycle latency
//   on        : 1 = effect enabled, 0 = bypass (out = in)
//   mode      : 0 = feed-forward, 1 = feedback
//   delay_len : delay in samples minus one (1..DEPTH samples)
//   mix_shift : wet weight exponent, 0..3
//   flush     : synchronous clear of the write pointer and the history fill count
// DEPTH must be a power of two so that the pointer arithmetic wraps naturally.
module echo_delay_line #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  echo_delay_line_if.slave smp,
  input  logic             on,
  input  logic             mode,
  input  logic [AW-1:0]    delay_len,
  input  logic [1:0]       mix_shift,
  input  logic             flush
);

  localparam int unsigned FW = AW + 1;     // fill counter width, holds 0..DEPTH
  localparam int unsigned XW = WIDTH + 2;  // headroom for the dry/wet sum

  localparam logic [FW-1:0]        FILL_MAX = FW'(DEPTH);
  localparam logic signed [XW-1:0] SAT_MAX  = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN  = {3'b111, {(WIDTH-1){1'b0}}};

  // Sample history; not reset, stale entries are masked by fill_q.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [FW-1:0]    fill_q,      fill_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [AW-1:0]    base_ptr;
  logic [FW-1:0]    base_fill;
  logic [FW-1:0]    dly_samples;
  logic [AW-1:0]    rd_addr;
  logic             hist_ok;
  logic [WIDTH-1:0] dly_smp;

  logic signed [XW-1:0] in_ext;
  logic signed [XW-1:0] dly_ext;
  logic signed [XW-1:0] dry_part;
  logic signed [XW-1:0] wet_part;
  logic signed [XW-1:0] mix_sum;
  logic [WIDTH-1:0]     mix_sat;
  logic [WIDTH-1:0]     y;

  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  // History lookup; a flush in the same cycle makes the sample behave as the first after a clear.
  always_comb begin
    base_ptr    = flush ? '0 : wr_ptr_q;
    base_fill   = flush ? '0 : fill_q;
    dly_samples = FW'(delay_len) + FW'(1);
    rd_addr     = base_ptr - delay_len - AW'(1);
    hist_ok     = (base_fill >= dly_samples);
    dly_smp     = hist_ok ? mem_q[rd_addr] : '0;
  end

  // Dry/wet mix: in - in*2^-s + d*2^-s, saturated back to WIDTH bits.
  always_comb begin
    in_ext   = {{2{smp.in_data[WIDTH-1]}}, smp.in_data};
    dly_ext  = {{2{dly_smp[WIDTH-1]}}, dly_smp};
    dry_part = in_ext - (in_ext >>> mix_shift);
    wet_part = dly_ext >>> mix_shift;
    mix_sum  = dry_part + wet_part;

    if (mix_sum > SAT_MAX) begin
      mix_sat = SAT_MAX[WIDTH-1:0];
    end else if (mix_sum < SAT_MIN) begin
      mix_sat = SAT_MIN[WIDTH-1:0];
    end else begin
      mix_sat = mix_sum[WIDTH-1:0];
    end

    y = on ? mix_sat : smp.in_data;
  end

  // Next-state: pointer, fill, output register and buffer write.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = base_ptr;
    mem_wdata   = (on && mode) ? y : smp.in_data;

    if (flush) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end

    if (smp.wren) begin
      out_valid_d = 1'b1;
      out_data_d  = y;
      mem_we      = 1'b1;
      wr_ptr_d    = base_ptr + AW'(1);
      fill_d      = (base_fill == FILL_MAX) ? base_fill : base_fill + FW'(1);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Buffer storage; the read above sees the pre-write contents in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign smp.out_data  = out_data_q;
  assign smp.out_valid = out_valid_q;

endmodule

// File: tb/tb_echo_delay_line.sv
// Self-checking bench for echo_delay_line: directed steps plus a randomized
// feedback run, with expected samples from a reference model pushed to a
// scoreboard queue at drive time and popped when the output strobe appears.
module tb_echo_delay_line;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam longint      MAXV  = (longint'(1) <<< (WIDTH-1)) - 1;
  localparam longint      MINV  = -(longint'(1) <<< (WIDTH-1));

  logic          clk = 1'b0;
  logic          reset;
  logic          on;
  logic          mode;
  logic [AW-1:0] delay_len;
  logic [1:0]    mix_shift;
  logic          flush;

  echo_delay_line_if #(.WIDTH(WIDTH)) ifc ();

  echo_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .smp       (ifc.slave),
    .on        (on),
    .mode      (mode),
    .delay_len (delay_len),
    .mix_shift (mix_shift),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_buf[DEPTH];
  int               m_ptr;
  int               m_fill;
  logic [WIDTH-1:0] cap[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one strobed sample using the current control inputs.
  task automatic model_step(input logic [WIDTH-1:0] x, output logic [WIDTH-1:0] y);
    longint           xi;
    longint           di;
    longint           yi;
    int               dlen;
    logic [WIDTH-1:0] rd;
    xi = longint'($signed(x));
    if (flush) begin
      m_ptr  = 0;
      m_fill = 0;
    end
    dlen = int'(delay_len) + 1;
    di   = 0;
    if (m_fill >= dlen) begin
      rd = m_buf[(m_ptr - dlen + 16) % 16];
      di = longint'($signed(rd));
    end
    if (on) begin
      yi = xi - (xi >>> mix_shift) + (di >>> mix_shift);
      if (yi > MAXV) yi = MAXV;
      if (yi < MINV) yi = MINV;
    end else begin
      yi = xi;
    end
    y = WIDTH'(yi);
    m_buf[m_ptr] = (on && mode) ? y : x;
    m_ptr = (m_ptr + 1) % 16;
    if (m_fill < 16) m_fill++;
  endtask

  // One strobed sample followed by one idle cycle; starts and ends just after a rising edge.
  task automatic send(input logic [WIDTH-1:0] x, output logic [WIDTH-1:0] got);
    logic [WIDTH-1:0] e;
    model_step(x, e);
    exp_q.push_back(e);
    ifc.in_data = x;
    ifc.wren    = 1'b1;
    @(posedge clk);
    #1;
    ifc.wren = 1'b0;
    flush    = 1'b0;
    got      = ifc.out_data;
    check("out_valid_after_wren", 32'(ifc.out_valid), 32'd1);
    e = exp_q.pop_front();
    check("out_data_scoreboard", 32'(got), 32'(e));
    @(posedge clk);
    #1;
    check("out_valid_idle", 32'(ifc.out_valid), 32'd0);
    check("out_data_idle", 32'(ifc.out_data), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush  = 1'b0;
    m_ptr  = 0;
    m_fill = 0;
    check("flush_idle_valid", 32'(ifc.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] x;

    reset       = 1'b1;
    on          = 1'b0;
    mode        = 1'b0;
    delay_len   = '0;
    mix_shift   = '0;
    flush       = 1'b0;
    ifc.in_data = '0;
    ifc.wren    = 1'b0;
    m_ptr       = 0;
    m_fill      = 0;
    #2 reset = 1'b0;
    #1;
    check("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    check("reset_out_data", 32'(ifc.out_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Feed-forward impulse
    on = 1'b1; mode = 1'b0; delay_len = 4'd3; mix_shift = 2'd2;
    for (int i = 0; i < 16; i++) send((i == 0) ? 24'h100000 : 24'h0, cap[i]);
    check("ff_s0", 32'(cap[0]), 32'h0C0000);
    check("ff_s4", 32'(cap[4]), 32'h040000);
    for (int i = 1; i < 16; i++) if (i != 4) check("ff_zero", 32'(cap[i]), 32'h0);

    // Feedback decay
    do_flush();
    mode = 1'b1;
    for (int i = 0; i < 16; i++) send((i == 0) ? 24'h100000 : 24'h0, cap[i]);
    check("fb_s0", 32'(cap[0]), 32'h0C0000);
    check("fb_s4", 32'(cap[4]), 32'h030000);
    check("fb_s8", 32'(cap[8]), 32'h00C000);
    check("fb_s12", 32'(cap[12]), 32'h003000);

    // Negative input and bypass
    do_flush();
    mode = 1'b0;
    send(24'hF00000, got);
    check("neg_wet", 32'(got), 32'hF40000);
    on = 1'b0;
    send(24'hF00000, got);
    check("bypass", 32'(got), 32'hF00000);

    // Fill masking at maximum delay and pointer wrap
    do_flush();
    on = 1'b1; delay_len = 4'd15; mix_shift = 2'd1;
    for (int i = 0; i < 40; i++) send(24'h000400, cap[i]);
    check("fill_s0", 32'(cap[0]), 32'h000200);
    check("fill_s15", 32'(cap[15]), 32'h000200);
    check("fill_s16", 32'(cap[16]), 32'h000400);
    check("fill_s39", 32'(cap[39]), 32'h000400);

    // Flush together with a strobe
    delay_len = 4'd3; mix_shift = 2'd2;
    for (int i = 0; i < 20; i++) send(24'h100000, got);
    flush = 1'b1;
    send(24'h0, got);
    check("flush_wren_out", 32'(got), 32'h0);
    for (int i = 0; i < 3; i++) begin
      send(24'h0, got);
      check("flush_masked", 32'(got), 32'h0);
    end

    // Reset pulsed mid-stream
    for (int i = 0; i < 20; i++) send(24'h100000, got);
    ifc.in_data = 24'h100000;
    ifc.wren    = 1'b1;
    model_step(24'h100000, got);
    @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(ifc.out_valid), 32'd1);
    #1;
    reset    = 1'b0;
    ifc.wren = 1'b0;
    #1;
    check("async_reset_valid", 32'(ifc.out_valid), 32'd0);
    check("async_reset_data", 32'(ifc.out_data), 32'd0);
    m_ptr  = 0;
    m_fill = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      send(24'h0, got);
      check("reset_masked", 32'(got), 32'h0);
    end

    // Saturation edge: full-scale delayed sample with zero dry weight
    do_flush();
    mix_shift = 2'd0; delay_len = 4'd0; mode = 1'b0;
    send(24'h7FFFFF, got);
    send(24'h000001, got);
    check("sat_delayed", 32'(got), 32'h7FFFFF);

    // Randomized full-scale feedback run
    do_flush();
    mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      on        = ($urandom_range(0, 9) != 0);
      mix_shift = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) delay_len = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      case ($urandom_range(0, 3))
        0:       x = 24'h7FFFFF;
        1:       x = 24'h800000;
        default: x = WIDTH'($urandom);
      endcase
      send(x, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_delay_line.md
Name: echo_delay_line

Overview:
Parametrised mono echo/delay stage for the sound-mixer sample path, operating on signed PCM samples qualified by a write-enable strobe. A circular sample buffer of DEPTH entries provides a runtime-selectable delay of 1..DEPTH samples. The delayed sample is mixed with the dry input using a selectable shift weight. Two modes are supported: feed-forward (single echo) and feedback (decaying repeats). The block sits between the sample source and the output mixer and replaces the fixed 16-tap, 1/4-mix delay stage.

Parameters:
WIDTH, 24, sample width in bits (signed two's complement)
DEPTH, 16, buffer entries and maximum delay in samples; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
clk  input  1  sample-path clock
reset  input  1  asynchronous, active-low reset
in_data  input  WIDTH  signed input sample
wren  input  1  input sample valid, one-cycle strobe per sample
on  input  1  1 = effect enabled, 0 = bypass
mode  input  1  0 = feed-forward, 1 = feedback
delay_len  input  AW  effective delay = delay_len+1 samples (1..DEPTH)
mix_shift  input  2  wet weight 2^-mix_shift (0..3)
flush  input  1  synchronous history clear
out_data  output  WIDTH  signed output sample
out_valid  output  1  out_data valid

Behaviour:
- Reset (reset=0, asynchronous): out_data=0, out_valid=0, wr_ptr=0, fill=0. Buffer RAM is not reset; stale contents are masked by fill.
- State:
  - wr_ptr (AW bits), wraps DEPTH-1 -> 0.
  - fill (AW+1 bits), saturates at DEPTH.
- Latency: exactly 1 cycle. A wren at cycle N gives out_valid=1 at N+1.
- Cycles without wren: out_valid=0, out_data=0. Buffer, pointer and fill are unchanged.
- Per wren, with D = delay_len+1:
  - d = buf[(wr_ptr - D) mod DEPTH] if fill >= D, else 0.
  - on=1: y = in - (in>>>mix_shift) + (d>>>mix_shift). Arithmetic shifts. Computed at WIDTH+2 bits, saturated to signed WIDTH.
  - on=0: y = in.
  - out_data <= y.
  - Buffer write at wr_ptr: in_data when mode=0 or on=0; y when mode=1 and on=1.
  - wr_ptr <= wr_ptr+1; fill <= min(fill+1, DEPTH).
- mix_shift=0 with on=1 outputs d only (pure delayed/wet).
- The read of buf[wr_ptr-D] happens before the write at wr_ptr in the same cycle. At D=DEPTH the old entry is read.
- Changing delay_len, mode, mix_shift or on takes effect on the next wren; the buffer is not cleared.
- flush=1 without wren: fill <= 0, wr_ptr <= 0.
- flush=1 with wren: the sample is processed with d=0, written at address 0, and wr_ptr=1, fill=1 afterwards.
- Reset asserted mid-stream: outputs drop to 0 immediately. History is invalidated, so the first D-1 outputs after release use d=0.
- Saturation limits: +2^(WIDTH-1)-1 and -2^(WIDTH-1).

Test Plan:
- Feed-forward impulse: WIDTH=24, DEPTH=16, delay_len=3, mix_shift=2, mode=0, on=1; input 0x100000 then zeros -> first output 0x0C0000, samples 1-3 are 0, sample 4 is 0x040000, all later samples 0.
- Feedback decay: same settings with mode=1 -> 0x0C0000 at sample 0, 0x030000 at sample 4, 0x00C000 at sample 8, 0x003000 at sample 12.
- Negative/bypass: input 0xF00000 with on=1, mix_shift=2, empty history -> 0xF40000; same input with on=0 -> 0xF00000. out_valid is high exactly 1 cycle after each wren and never otherwise.
- Fill masking and wrap: delay_len=15, mix_shift=1, constant 0x000400 for 40 wrens -> outputs 0-15 are 0x000200, outputs 16 onward are 0x000400; wr_ptr wraps with no glitch.
- Flush and reset: after 20 samples of 0x100000, assert flush together with a wren of 0 -> that output is 0 and the next D-1 outputs are 0. Repeat with reset pulsed low mid-cycle -> out_data and out_valid are 0 asynchronously, same masking after release.
- Saturation: mix_shift=0, delay_len=0, input 0x7FFFFF then 0x000001 -> second output 0x7FFFFF (the delayed sample, no wrap). Bench checks no overflow across randomized full-scale inputs in feedback mode.
